// File: rtl/ca_power_sequencer.sv
// Initiator side of the CA interlock handshake: sequences fan, G1 and CA supply
// bring-up, supervises the running CA supply and trips to a latched fault with cooldown.
module ca_power_sequencer #(
   parameter int FAN_SPINUP    = 128,
   parameter int G1_TIMEOUT    = 64,
   parameter int PERM_TIMEOUT  = 256,
   parameter int CA_OK_TIMEOUT = 4096,
   parameter int COOLDOWN      = 3840,
   parameter int MAX_RETRIES   = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_cmd,
   input  logic       stop_cmd,
   input  logic       fault_ack,
   input  logic       i_not_alarm,
   input  logic       i_g1_ok,
   input  logic       i_ca_perm_n,
   input  logic       i_not_ca_ok,
   input  logic       i_i_ca_high_n,
   input  logic       i_u_ca_low_n,
   output logic       o_fan_on,
   output logic       o_g1_enable,
   output logic       o_ca_ps_act,
   output logic       o_ready,
   output logic       o_fault,
   output logic       o_lockout,
   output logic [2:0] o_fault_code,
   output logic [2:0] o_state,
   output logic [1:0] o_retry_cnt
);

   localparam int M1   = (FAN_SPINUP > G1_TIMEOUT) ? FAN_SPINUP : G1_TIMEOUT;
   localparam int M2   = (M1 > PERM_TIMEOUT) ? M1 : PERM_TIMEOUT;
   localparam int M3   = (M2 > CA_OK_TIMEOUT) ? M2 : CA_OK_TIMEOUT;
   localparam int MAXP = (M3 > COOLDOWN) ? M3 : COOLDOWN;
   localparam int TW   = $clog2(MAXP + 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FAN_START = 3'd1,
      S_G1_WAIT   = 3'd2,
      S_CA_REQ    = 3'd3,
      S_CA_RAMP   = 3'd4,
      S_RUN       = 3'd5,
      S_FAULT     = 3'd6,
      S_COOLDOWN  = 3'd7
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    code_q, code_d;
   logic [1:0]    retry_q, retry_d;
   logic          lock_q, lock_d;
   logic [2:0]    fc;
   logic [1:0]    retry_inc;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         code_q  <= '0;
         retry_q <= '0;
         lock_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         code_q  <= code_d;
         retry_q <= retry_d;
         lock_q  <= lock_d;
      end
   end

   assign retry_inc = (retry_q == 2'd3) ? 2'd3 : retry_q + 2'd1;

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      retry_d = retry_q;
      lock_d  = lock_q;
      fc      = 3'd0;
      // Supervision hazards outrank stop, which outranks progress and timeouts.
      if (state_q inside {S_FAN_START, S_G1_WAIT, S_CA_REQ, S_CA_RAMP, S_RUN}) begin
         if (!i_not_alarm)                        fc = 3'd1;
         else if (state_q == S_RUN && !i_i_ca_high_n) fc = 3'd5;
         else if (state_q == S_RUN && !i_u_ca_low_n)  fc = 3'd6;
         else if (state_q == S_RUN && i_not_ca_ok)    fc = 3'd7;
      end
      case (state_q)
         S_IDLE: begin
            if (start_cmd && i_not_alarm && !lock_q) begin
               state_d = S_FAN_START;
               code_d  = 3'd0;
            end
            if (stop_cmd && fault_ack) begin
               lock_d  = 1'b0;
               retry_d = 2'd0;
            end
         end
         S_FAULT: if (fault_ack) state_d = S_COOLDOWN;
         S_COOLDOWN: if (timer_q == TW'(COOLDOWN - 1)) state_d = S_IDLE;
         default: begin
            if (fc == 3'd0) begin
               if (stop_cmd) state_d = S_COOLDOWN;
               else begin
                  case (state_q)
                     S_FAN_START: if (timer_q == TW'(FAN_SPINUP - 1)) state_d = S_G1_WAIT;
                     S_G1_WAIT: begin
                        if (i_g1_ok) state_d = S_CA_REQ;
                        else if (timer_q == TW'(G1_TIMEOUT - 1)) fc = 3'd2;
                     end
                     S_CA_REQ: begin
                        if (!i_ca_perm_n) state_d = S_CA_RAMP;
                        else if (timer_q == TW'(PERM_TIMEOUT - 1)) fc = 3'd3;
                     end
                     S_CA_RAMP: begin
                        if (!i_not_ca_ok) begin
                           state_d = S_RUN;
                           retry_d = 2'd0;
                        end else if (timer_q == TW'(CA_OK_TIMEOUT - 1)) fc = 3'd4;
                     end
                     default: ;
                  endcase
               end
            end
         end
      endcase
      if (fc != 3'd0) begin
         state_d = S_FAULT;
         code_d  = fc;
         retry_d = retry_inc;
         if (int'(retry_inc) >= MAX_RETRIES) lock_d = 1'b1;
      end
   end

   assign timer_d = (state_d != state_q) ? '0 : timer_q + TW'(1);

   assign o_fan_on     = (state_q != S_IDLE);
   assign o_g1_enable  = state_q inside {S_G1_WAIT, S_CA_REQ, S_CA_RAMP, S_RUN};
   assign o_ca_ps_act  = state_q inside {S_CA_REQ, S_CA_RAMP, S_RUN};
   assign o_ready      = (state_q == S_RUN);
   assign o_fault      = (state_q == S_FAULT);
   assign o_lockout    = lock_q;
   assign o_fault_code = code_q;
   assign o_state      = state_q;
   assign o_retry_cnt  = retry_q;

endmodule
